// File: rtl/wb_retire_stage_pkg.sv
// Shared definitions for the write-back/retire stage: stall bus encoding and lane packing helpers.
// Every flattened per-lane bus puts lane 0 in the least-significant field.
package wb_retire_stage_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit offset of a lane's field inside a flattened per-lane bus.
    function automatic int lane_lo(input int lane, input int field_w);
        return lane * field_w;
    endfunction

endpackage

// File: rtl/wb_retire_stage_fifo.sv
// Trace FIFO for retired writes: accepts up to LANES pushes per edge and pops one entry per edge.
// The pop uses the pre-edge head. Pushes that do not fit are dropped and set a sticky overflow flag.
module wb_trace_fifo
    import wb_retire_stage_pkg::*;
#(
    parameter int ENT_W = 73,
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LANES-1:0]               push_vld,
    input  logic [LANES*ENT_W-1:0]         push_data,
    output logic [ENT_W-1:0]               head_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    int               n_pop;
    int               n_acc;
    int               n_free;

    always_comb begin
        mem_d  = mem_q;
        ovf_d  = ovf_q;
        n_pop  = (count_q != '0) ? 1 : 0;
        n_free = DEPTH - int'(count_q) + n_pop;
        n_acc  = 0;
        for (int i = 0; i < LANES; i++) begin
            if (push_vld[i]) begin
                if (n_acc < n_free) begin
                    mem_d[PTR_W'(int'(wptr_q) + n_acc)] = push_data[lane_lo(i, ENT_W) +: ENT_W];
                    n_acc = n_acc + 1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        wptr_d  = PTR_W'(int'(wptr_q) + n_acc);
        rptr_d  = PTR_W'(int'(rptr_q) + n_pop);
        count_d = CNT_W'(int'(count_q) - n_pop + n_acc);
    end

    // Storage is not reset; the empty state is carried by count and the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head_data = mem_q[rptr_q];
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/wb_retire_stage.sv
// Multi-lane write-back stage: registers the MEM result, drives RF writes and forwarding,
// and serialises retired writes through a trace FIFO onto the single-write debug port.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int PC_W        = 32,
    parameter int LANES       = 2,
    parameter int STALL_W     = 6,
    parameter int STAGE_IDX   = 4,
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 32,
    parameter int ZERO_REG    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [STALL_W-1:0]                stall,
    input  logic                              in_valid,
    input  logic [PC_W-1:0]                   in_pc,
    input  logic [LANES-1:0]                  in_we,
    input  logic [LANES*ADDR_W-1:0]           in_waddr,
    input  logic [LANES*DATA_W-1:0]           in_wdata,
    input  logic [LANES*DATA_W/8-1:0]         in_wstrb,
    output logic [LANES-1:0]                  rf_we,
    output logic [LANES*ADDR_W-1:0]           rf_waddr,
    output logic [LANES*DATA_W-1:0]           rf_wdata,
    output logic [LANES*DATA_W/8-1:0]         rf_wstrb,
    output logic [LANES*(1+ADDR_W+DATA_W)-1:0] fwd_bus,
    output logic                              stall_req,
    output logic [CNT_W-1:0]                  retire_cnt,
    output logic                              trace_overflow,
    output logic [PC_W-1:0]                   debug_wb_pc,
    output logic [DATA_W/8-1:0]               debug_wb_rf_wen,
    output logic [ADDR_W-1:0]                 debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                 debug_wb_rf_wdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int FWD_W  = 1 + ADDR_W + DATA_W;
    localparam int ENT_W  = PC_W + STRB_W + ADDR_W + DATA_W;
    localparam int FCNT_W = $clog2(TRACE_DEPTH) + 1;

    logic                      vld_p0_q,   vld_p0_d;
    logic [PC_W-1:0]           pc_p0_q,    pc_p0_d;
    logic [LANES-1:0]          we_p0_q,    we_p0_d;
    logic [LANES*ADDR_W-1:0]   waddr_p0_q, waddr_p0_d;
    logic [LANES*DATA_W-1:0]   wdata_p0_q, wdata_p0_d;
    logic [LANES*STRB_W-1:0]   wstrb_p0_q, wstrb_p0_d;
    logic                      fresh_q,    fresh_d;
    logic [CNT_W-1:0]          retire_cnt_q, retire_cnt_d;

    logic [LANES-1:0]          lane_cand;
    logic [LANES-1:0]          lane_en;
    logic [LANES-1:0]          push_vld;
    logic [LANES*ENT_W-1:0]    push_data;
    logic [ENT_W-1:0]          head_data;
    logic [FCNT_W-1:0]         fifo_cnt;
    logic                      fifo_ovf;
    logic                      stall_self;
    logic                      stall_next;
    logic                      unused_stall_bits;

    assign stall_self        = stall[STAGE_IDX];
    assign stall_next        = stall[STAGE_IDX+1];
    assign unused_stall_bits = ^stall;

    // Pipeline register: flush and bubble clear, stall of a later stage holds, otherwise load.
    always_comb begin
        vld_p0_d   = vld_p0_q;
        pc_p0_d    = pc_p0_q;
        we_p0_d    = we_p0_q;
        waddr_p0_d = waddr_p0_q;
        wdata_p0_d = wdata_p0_q;
        wstrb_p0_d = wstrb_p0_q;
        fresh_d    = 1'b0;
        if (flush || (stall_self == STOP && stall_next == NO_STOP)) begin
            vld_p0_d   = 1'b0;
            pc_p0_d    = '0;
            we_p0_d    = '0;
            waddr_p0_d = '0;
            wdata_p0_d = '0;
            wstrb_p0_d = '0;
        end else if (stall_self == NO_STOP) begin
            vld_p0_d   = in_valid;
            pc_p0_d    = in_pc;
            we_p0_d    = in_we;
            waddr_p0_d = in_waddr;
            wdata_p0_d = in_wdata;
            wstrb_p0_d = in_wstrb;
            fresh_d    = in_valid;
        end
    end

    assign retire_cnt_d = retire_cnt_q + CNT_W'(fresh_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q     <= 1'b0;
            pc_p0_q      <= '0;
            we_p0_q      <= '0;
            waddr_p0_q   <= '0;
            wdata_p0_q   <= '0;
            wstrb_p0_q   <= '0;
            fresh_q      <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            vld_p0_q     <= vld_p0_d;
            pc_p0_q      <= pc_p0_d;
            we_p0_q      <= we_p0_d;
            waddr_p0_q   <= waddr_p0_d;
            wdata_p0_q   <= wdata_p0_d;
            wstrb_p0_q   <= wstrb_p0_d;
            fresh_q      <= fresh_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // ---- p0 -> RF / forwarding / trace ----
    // A lane is dropped when a higher lane writes the same register, so the highest lane wins.
    always_comb begin
        lane_cand = '0;
        lane_en   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_cand[i] = vld_p0_q && we_p0_q[i]
                && (wstrb_p0_q[lane_lo(i, STRB_W) +: STRB_W] != '0)
                && !((ZERO_REG != 0) && (waddr_p0_q[lane_lo(i, ADDR_W) +: ADDR_W] == '0));
        end
        for (int i = 0; i < LANES; i++) begin
            lane_en[i] = lane_cand[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_cand[j] && (waddr_p0_q[lane_lo(j, ADDR_W) +: ADDR_W]
                                     == waddr_p0_q[lane_lo(i, ADDR_W) +: ADDR_W])) begin
                    lane_en[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rf_we     = lane_en;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_wstrb  = '0;
        fwd_bus   = '0;
        push_vld  = fresh_q ? lane_en : '0;
        push_data = '0;
        for (int i = 0; i < LANES; i++) begin
            push_data[lane_lo(i, ENT_W) +: ENT_W] = {pc_p0_q,
                                                     wstrb_p0_q[lane_lo(i, STRB_W) +: STRB_W],
                                                     waddr_p0_q[lane_lo(i, ADDR_W) +: ADDR_W],
                                                     wdata_p0_q[lane_lo(i, DATA_W) +: DATA_W]};
            if (lane_en[i]) begin
                rf_waddr[lane_lo(i, ADDR_W) +: ADDR_W] = waddr_p0_q[lane_lo(i, ADDR_W) +: ADDR_W];
                rf_wdata[lane_lo(i, DATA_W) +: DATA_W] = wdata_p0_q[lane_lo(i, DATA_W) +: DATA_W];
                rf_wstrb[lane_lo(i, STRB_W) +: STRB_W] = wstrb_p0_q[lane_lo(i, STRB_W) +: STRB_W];
                fwd_bus[lane_lo(i, FWD_W) +: FWD_W]   = {1'b1,
                                                         waddr_p0_q[lane_lo(i, ADDR_W) +: ADDR_W],
                                                         wdata_p0_q[lane_lo(i, DATA_W) +: DATA_W]};
            end
        end
    end

    wb_trace_fifo #(
        .ENT_W (ENT_W),
        .DEPTH (TRACE_DEPTH),
        .LANES (LANES)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_data (push_data),
        .head_data (head_data),
        .count     (fifo_cnt),
        .overflow  (fifo_ovf)
    );

    // Headroom of 2*LANES leaves space for one more load arriving before the stall lands.
    assign stall_req      = (TRACE_DEPTH - int'(fifo_cnt)) < (2 * LANES);
    assign retire_cnt     = retire_cnt_q;
    assign trace_overflow = fifo_ovf;

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (fifo_cnt != '0) begin
            {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} = head_data;
        end
    end

endmodule
